// File: rtl/seq_alu.sv
// Sequential ALU: NOT-A / NAND / ADD finish in one cycle; MUL is a WIDTH-cycle shift-add.
// Optional registered zero-result flag enabled by defining SEQ_ALU_ZERO_FLAG_EN.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           select,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
`ifdef SEQ_ALU_ZERO_FLAG_EN
    ,
    output logic                 zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0]   ZERO_2W  = {(2*WIDTH){1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [1:0]           sel_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   op_result_s;
    logic [2*WIDTH-1:0]   z_next_s;
    logic                 load_z_s;

    // Next-state decode, partial product and single-cycle results.
    always_comb begin
        state_next_s = state_r;
        prod_s       = acc_r;
        op_result_s  = ZERO_2W;
        z_next_s     = ZERO_2W;
        load_z_s     = 1'b0;

        if (mplier_r[0]) begin
            prod_s = acc_r + mcand_r;
        end else begin
            prod_s = acc_r;
        end

        case (select)
            2'b00:   op_result_s = {{WIDTH{1'b0}}, ~a};
            2'b01:   op_result_s = {{WIDTH{1'b0}}, ~(a & b)};
            2'b10:   op_result_s = {{(WIDTH-1){1'b0}}, {1'b0, a} + {1'b0, b}};
            default: op_result_s = ZERO_2W;
        endcase

        case (state_r)
            IDLE: begin
                if (start) begin
                    if (select == 2'b11) begin
                        state_next_s = MUL;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                // A corrupted opcode register abandons the multiply rather than reporting garbage.
                if (sel_r != 2'b11) begin
                    state_next_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = MUL;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase

        load_z_s = (state_next_s == DONE);
        if (state_r == MUL) begin
            z_next_s = prod_s;
        end else begin
            z_next_s = op_result_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture and shift-add datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_r  <= ZERO_2W;
            mplier_r <= {WIDTH{1'b0}};
            sel_r    <= 2'b00;
            acc_r    <= ZERO_2W;
            cnt_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= {{WIDTH{1'b0}}, a};
                        mplier_r <= b;
                        sel_r    <= select;
                        acc_r    <= ZERO_2W;
                        cnt_r    <= {CW{1'b0}};
                    end
                end
                MUL: begin
                    acc_r    <= prod_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Registered result and handshake outputs, all updated from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z    <= ZERO_2W;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next_s != IDLE);
            done <= (state_next_s == DONE);
            if (load_z_s) begin
                z <= z_next_s;
            end
        end
    end

`ifdef SEQ_ALU_ZERO_FLAG_EN
    // Zero flag tracks z and is refreshed only when z is loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero <= 1'b1;
        end else if (load_z_s) begin
            zero <= (z_next_s == ZERO_2W);
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed and random operations against an arithmetic model.
module tb_seq_alu;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [1:0]     select;
    logic           start;
    logic           busy;
    logic           done;
    logic [2*W-1:0] z;
`ifdef SEQ_ALU_ZERO_FLAG_EN
    logic           zero;
`endif

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] zprev = '0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .select(select),
        .start(start), .busy(busy), .done(done), .z(z)
`ifdef SEQ_ALU_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result of an operation from its arithmetic definition.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                              input logic [1:0] ms);
        int x, y, mask, r;
        x = ma; y = mb; mask = (1 << W) - 1;
        case (ms)
            2'b11:   r = x * y;
            2'b10:   r = x + y;
            2'b01:   r = mask - (x & y);
            default: r = mask - x;
        endcase
        return r[2*W-1:0];
    endfunction

    task automatic chk_z(input string tag, input logic [2*W-1:0] ez);
        chk(tag, z, ez);
`ifdef SEQ_ALU_ZERO_FLAG_EN
        chk({tag, "_zero"}, zero, (ez == '0));
`endif
    endtask

    // Run one operation; with poke, start is held high (select=ADD) for the whole busy window.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] isel,
                         input bit poke);
        logic [2*W-1:0] ez;
        int lat;
        ez  = model(ia, ib, isel);
        lat = (isel == 2'b11) ? W + 1 : 1;
        @(negedge clk);
        a = ia; b = ib; select = isel; start = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a = W'($urandom); b = W'($urandom);
                select = poke ? 2'b10 : 2'($urandom);
                start = poke;
            end
            chk("busy", busy, 1'b1);
            chk("done", done, (c == lat));
            chk_z((c == lat) ? "z_result" : "z_hold", (c == lat) ? ez : zprev);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after", busy, 1'b0);
        chk("done_after", done, 1'b0);
        chk_z("z_after", ez);
        zprev = ez;
    endtask

    initial begin
        reset = 1'b1; a = '0; b = '0; select = 2'b00; start = 1'b0;
        #1;
        chk("rst_z", z, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
`ifdef SEQ_ALU_ZERO_FLAG_EN
        chk("rst_zero", zero, 1'b1);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        do_op(4'd3, 4'd5, 2'b11, 1'b0);
        do_op(4'd15, 4'd15, 2'b11, 1'b0);
        do_op(4'd15, 4'd15, 2'b10, 1'b0);
        do_op(4'b1010, 4'b0110, 2'b01, 1'b0);
        do_op(4'h5, 4'h0, 2'b00, 1'b0);
        do_op(4'd0, 4'd9, 2'b11, 1'b0);
        do_op(4'd1, 4'd0, 2'b10, 1'b0);
        do_op(4'd7, 4'd0, 2'b11, 1'b0);
        do_op(4'd6, 4'd7, 2'b11, 1'b1);
        do_op(4'd9, 4'd9, 2'b10, 1'b1);
        do_op(4'hF, 4'hF, 2'b01, 1'b0);
        do_op(4'h0, 4'h0, 2'b00, 1'b0);

        // Reset two cycles into a multiply aborts it.
        @(negedge clk);
        a = 4'd3; b = 4'd5; select = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_z", z, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
            chk("abort_idle", busy, 1'b0);
        end
        zprev = '0;
        do_op(4'd3, 4'd5, 2'b11, 1'b0);

        // Reset during the DONE cycle of a single-cycle op suppresses the pulse.
        @(negedge clk);
        a = 4'd1; b = 4'd2; select = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_abort_done", done, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort2_done", done, 1'b0);
        chk("abort2_z", z, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        zprev = '0;

        for (int i = 0; i < 30; i++) begin
            do_op(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
